// File: rtl/reaction_timer_if.sv
// Purpose : bundles the reaction tester front-end signals (raw switch/button in,
//           synchronised start, status flags and reaction time out).
// Latency : none, wiring only; no backpressure, all signals are plain levels.
// Ports   : master = stimulus/display side, slave = reaction_timer side.
//           start_sw, react_btn   raw level inputs (master -> slave)
//           start, random_finish, react, react_exceed, t_react[31:0]
//                                 registered status outputs (slave -> master)
interface reaction_timer_if;
    logic        start_sw;
    logic        react_btn;
    logic        start;
    logic        random_finish;
    logic        react;
    logic [31:0] t_react;
    logic        react_exceed;

    modport master (
        output start_sw, react_btn,
        input  start, random_finish, react, t_react, react_exceed
    );

    modport slave (
        input  start_sw, react_btn,
        output start, random_finish, react, t_react, react_exceed
    );
endinterface

// File: rtl/reaction_timer.sv
// Purpose : reaction tester front end; synchronises start/react, waits a random
//           delay, then times the press in ms and flags early presses/timeouts.
// Latency : start 2 cycles after start_sw, react 3 cycles after the raw press
//           edge; no backpressure, outputs are levels held until start drops.
// Ports   : clock, reset (async, active-high), bus (reaction_timer_if.slave).
// Option  : define REACT_DEBOUNCE_EN to filter the synchronised button over
//           DEBOUNCE_MS consecutive ms ticks.
module reaction_timer #(
    parameter int unsigned TICK_DIV         = 100000,
    parameter int unsigned MIN_DELAY_MS     = 1000,
    parameter int unsigned DELAY_RANGE_LOG2 = 11,
    parameter int unsigned TIMEOUT_MS       = 1000,
    parameter int unsigned DEBOUNCE_MS      = 10
) (
    input  logic             clock,
    input  logic             reset,
    reaction_timer_if.slave  bus
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ARMED, S_EARLY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    start_sync_q, start_sync_d;
    logic [1:0]    react_sync_q, react_sync_d;
    logic          start_prev_q, start_prev_d;
    logic          react_prev_q, react_prev_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [31:0]   ms_cnt_q, ms_cnt_d;
    logic [31:0]   delay_q, delay_d;
    logic          random_finish_q, random_finish_d;
    logic          react_q, react_d;
    logic          react_exceed_q, react_exceed_d;
    logic [31:0]   t_react_q, t_react_d;

    logic start_lvl, react_lvl, react_evt, tick;

    assign start_lvl = start_sync_q[1];
    assign tick      = (tick_cnt_q == TICK_LAST);

`ifdef REACT_DEBOUNCE_EN
    // Filtered level only follows the synchroniser once it has held a new
    // value for DEBOUNCE_MS whole ticks; any return to the old level restarts.
    logic        db_lvl_q, db_lvl_d;
    logic [31:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = db_cnt_q;
        if (react_sync_q[1] == db_lvl_q) begin
            db_cnt_d = '0;
        end else if (tick) begin
            if (db_cnt_q + 32'd1 >= 32'(DEBOUNCE_MS)) begin
                db_lvl_d = react_sync_q[1];
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            db_lvl_q <= db_lvl_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign react_lvl = db_lvl_q;
`else
    assign react_lvl = react_sync_q[1];
`endif

    // Edge against a history flop that always tracks the level, so a button
    // already held when the test starts can never produce an event.
    assign react_evt = react_lvl & ~react_prev_q;

    always_comb begin
        start_sync_d    = {start_sync_q[0], bus.start_sw};
        react_sync_d    = {react_sync_q[0], bus.react_btn};
        start_prev_d    = start_lvl;
        react_prev_d    = react_lvl;
        lfsr_d          = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        tick_cnt_d      = tick ? '0 : tick_cnt_q + TW'(1);
        state_d         = state_q;
        ms_cnt_d        = ms_cnt_q;
        delay_d         = delay_q;
        random_finish_d = random_finish_q;
        react_d         = react_q;
        react_exceed_d  = react_exceed_q;
        t_react_d       = t_react_q;

        // Realign the ms grid with the start of a test.
        if (start_lvl && !start_prev_q) begin
            tick_cnt_d = '0;
        end

        if (!start_lvl) begin
            state_d         = S_IDLE;
            ms_cnt_d        = '0;
            random_finish_d = 1'b0;
            react_d         = 1'b0;
            react_exceed_d  = 1'b0;
            t_react_d       = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_WAIT;
                    ms_cnt_d   = '0;
                    tick_cnt_d = '0;
                    delay_d    = 32'(MIN_DELAY_MS) + 32'(lfsr_q[DELAY_RANGE_LOG2-1:0]);
                end
                S_WAIT: begin
                    if (react_evt) begin
                        state_d = S_EARLY;
                        react_d = 1'b1;
                    end else if (tick) begin
                        ms_cnt_d = ms_cnt_q + 32'd1;
                        // Arm on the tick that brings the count to delay so the
                        // flag appears the very next cycle.
                        if (ms_cnt_q + 32'd1 >= delay_q) begin
                            state_d         = S_ARMED;
                            random_finish_d = 1'b1;
                            t_react_d       = '0;
                        end
                    end
                end
                S_ARMED: begin
                    if (react_evt) begin
                        state_d = S_DONE;
                        react_d = 1'b1;
                    end else if (t_react_q >= 32'(TIMEOUT_MS)) begin
                        state_d        = S_DONE;
                        react_exceed_d = 1'b1;
                    end else if (tick) begin
                        t_react_d = t_react_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            start_sync_q    <= '0;
            react_sync_q    <= '0;
            start_prev_q    <= 1'b0;
            react_prev_q    <= 1'b0;
            lfsr_q          <= 16'hACE1;
            tick_cnt_q      <= '0;
            ms_cnt_q        <= '0;
            delay_q         <= '0;
            random_finish_q <= 1'b0;
            react_q         <= 1'b0;
            react_exceed_q  <= 1'b0;
            t_react_q       <= '0;
        end else begin
            state_q         <= state_d;
            start_sync_q    <= start_sync_d;
            react_sync_q    <= react_sync_d;
            start_prev_q    <= start_prev_d;
            react_prev_q    <= react_prev_d;
            lfsr_q          <= lfsr_d;
            tick_cnt_q      <= tick_cnt_d;
            ms_cnt_q        <= ms_cnt_d;
            delay_q         <= delay_d;
            random_finish_q <= random_finish_d;
            react_q         <= react_d;
            react_exceed_q  <= react_exceed_d;
            t_react_q       <= t_react_d;
        end
    end

    assign bus.start         = start_lvl;
    assign bus.random_finish = random_finish_q;
    assign bus.react         = react_q;
    assign bus.react_exceed  = react_exceed_q;
    assign bus.t_react       = t_react_q;
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Front-end control stage of the reaction tester; it feeds the seven-segment display stage. It synchronises the start switch and the react button, and waits a pseudo-random delay before arming. It then measures the reaction time in milliseconds and flags early presses and timeouts. Its outputs are `start`, `random_finish`, `react`, `t_react` and `react_exceed`, which the display stage consumes directly.

## Interface
- `TICK_DIV`, 100000: clock cycles per 1 ms tick (100 MHz board clock).
- `MIN_DELAY_MS`, 1000: minimum random wait, ms.
- `DELAY_RANGE_LOG2`, 11: random extra wait is 0..2^N-1 ms.
- `TIMEOUT_MS`, 1000: reaction window, ms.
- `DEBOUNCE_MS`, 10: debounce filter length, ms. Used only with `REACT_DEBOUNCE_EN`.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start_sw`  in  1  raw start switch, level.
- `react_btn`  in  1  raw react button, level.
- `start`  out  1  synchronised `start_sw`.
- `random_finish`  out  1  random delay elapsed; held until the test ends.
- `react`  out  1  valid press captured; held until the test ends.
- `t_react`  out  32  reaction time, ms.
- `react_exceed`  out  1  timeout flag; held until the test ends.

## Operation
- Both raw inputs pass through 2-FF synchronisers.
- A react event is a rising edge of the synchronised (and, if enabled, debounced) button.
- A held button never generates an event.
- LFSR: 16-bit Galois, taps 0xB400, seed 0xACE1 on reset, advances every clock.
- ms tick: counter counts 0..TICK_DIV-1 and pulses `tick` for one cycle at TICK_DIV-1. It clears to 0 on the `start` rising edge and on IDLE→WAIT.
- FSM states and transitions:
  - IDLE: all outputs 0 except `start`.
    - `start`=1 → WAIT, and latch `delay = MIN_DELAY_MS + lfsr[DELAY_RANGE_LOG2-1:0]`.
  - WAIT: a ms counter increments on `tick`.
    - React event → EARLY, `react`=1.
    - Otherwise, when the count reaches `delay` → ARMED, `random_finish`=1, `t_react`=0.
    - If both occur in the same cycle, the react event wins (EARLY).
  - ARMED: `t_react` increments on `tick`.
    - React event → DONE, `react`=1, `t_react` frozen.
    - Otherwise, `t_react`==TIMEOUT_MS → DONE, `react_exceed`=1.
    - If the react event and the timeout coincide, the react event wins: `react`=1 and `react_exceed`=0.
  - EARLY / DONE: all outputs frozen. Further presses are ignored, so `react` stays 0 after a timeout.
- From any state, `start`=0 → IDLE. `random_finish`, `react`, `react_exceed` and `t_react` clear the next cycle.
- `t_react` never exceeds TIMEOUT_MS; no wrap is possible.

## Timing
- Reset values:
  - all outputs 0.
  - FSM IDLE.
  - synchronisers, tick counter and ms counter 0.
  - LFSR 0xACE1.
- A mid-test reset aborts immediately and takes effect asynchronously.
- Raw input → `start`: 2 cycles.
- Raw react edge → `react`: 3 cycles (2 synchroniser cycles + 1 registered).
- All outputs are registered and change only on `clock` rising edges.
- `random_finish` rises in the cycle after the tick that brings the ms count to `delay`.
- `t_react` changes in the cycle after each tick.

## Configuration
- `REACT_DEBOUNCE_EN` defined:
  - The synchronised button must hold a new level for `DEBOUNCE_MS` consecutive ticks before the filtered level changes.
  - Adds DEBOUNCE_MS ms of latency to the react path.
  - Glitches shorter than the filter window are rejected.
- Undefined: the filter is absent and events come straight from the synchroniser.

## Test plan
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=8, DELAY_RANGE_LOG2=3, TIMEOUT_MS=200, no debounce.
- Reset, then `start_sw`=1 with no press:
  - `start`=1 after 2 cycles.
  - `random_finish` rises after 8..15 ms (32..60 cycles).
  - `react_exceed`=1 when `t_react`=200.
  - A later press leaves `react`=0.
- Press 150 ms after `random_finish`:
  - `react`=1 and `t_react`=150 (±1).
  - `t_react` stays frozen while the button toggles.
- Press during WAIT:
  - `react`=1 and `random_finish` stays 0 indefinitely.
- Button held before `start_sw` rises and released after `random_finish`:
  - No event, so `react`=0.
  - A new press then captures normally.
- Drop `start_sw` in ARMED:
  - All flags and `t_react` are 0 within 3 cycles.
  - Re-raising `start_sw` starts a fresh delay.
- Assert `reset` mid-ARMED:
  - Outputs are 0 asynchronously.
  - After release with `start_sw` still 1, a new test begins.
